// File: rtl/rosc_entropy_array.sv
// Ring-oscillator entropy source: NUM_LOOPS inverter rings, sampled on a divided tick,
// XOR-folded into one bit per tick and packed into WORD_WIDTH words on a valid/ack handshake.
`timescale 1ns/1ps

module inv1 (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module rosc_entropy_array #(
    parameter int NUM_LOOPS   = 8,
    parameter int LOOP_LEN    = 7,
    parameter int SEED_CYCLES = 4,
    parameter int SAMPLE_DIV  = 16,
    parameter int WORD_WIDTH  = 32,
    parameter int STUCK_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  reseed,
    input  logic [NUM_LOOPS-1:0]  seed_pattern,
    output logic [WORD_WIDTH-1:0] entropy_data,
    output logic                  entropy_valid,
    input  logic                  entropy_ack,
    output logic [NUM_LOOPS-1:0]  raw_bits,
    output logic                  busy,
    output logic                  stuck_error
);
    localparam int SCW = $clog2(SAMPLE_DIV);
    localparam int BCW = $clog2(WORD_WIDTH + 1);
    localparam int KCW = $clog2(STUCK_LIMIT + 1);
    localparam int SDW = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SEED, RUN, HOLD} state_t;

    state_t               state, state_nxt;
    logic                 ring_ctrl;
    logic [NUM_LOOPS-1:0] loop_out;
    logic [NUM_LOOPS-1:0] sync_q;
    logic [SDW-1:0]       seed_cnt;
    logic [SCW-1:0]       sample_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic                 tick, seed_done, seed_entry, last_bit;
    logic [NUM_LOOPS-1:0] prev_bits;
    logic                 have_prev;
    logic [KCW-1:0]       stuck_cnt     [NUM_LOOPS];
    logic [KCW-1:0]       stuck_cnt_nxt [NUM_LOOPS];
    logic                 stuck_hit;

    // Rings: every stage is forced to the seed bit while ring_ctrl is high, otherwise
    // the stages chain into a free-running odd-length inverter loop.
    for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_loop
        logic [LOOP_LEN-1:0] chain;
        for (genvar k = 0; k < LOOP_LEN; k++) begin : g_stage
            logic stage_in;
            if (k == 0) begin : g_first
                assign stage_in = ring_ctrl ? seed_pattern[i] : loop_out[i];
            end else begin : g_rest
                assign stage_in = ring_ctrl ? seed_pattern[i] : chain[k-1];
            end
            inv1 u_inv (.a(stage_in), .y(chain[k]));
        end
        assign loop_out[i] = chain[LOOP_LEN-1];
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            raw_bits <= '0;
        end else begin
            sync_q   <= loop_out;
            raw_bits <= sync_q;
        end
    end

    assign tick       = (state == RUN) && (sample_cnt == SCW'(SAMPLE_DIV - 1));
    assign last_bit   = (bit_cnt == BCW'(WORD_WIDTH - 1));
    assign seed_done  = (seed_cnt == SDW'(SEED_CYCLES - 1));
    assign seed_entry = enable && ((state == IDLE) || reseed);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: a default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = SEED;
                SEED: if (reseed) state_nxt = SEED;
                      else if (seed_done) state_nxt = RUN;
                RUN:  if (reseed) state_nxt = SEED;
                      else if (tick && last_bit) state_nxt = HOLD;
                HOLD: if (reseed) state_nxt = SEED;
                      else if (entropy_ack) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ring_ctrl = (state == IDLE) || (state == SEED);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entropy_data  <= '0;
            entropy_valid <= 1'b0;
            seed_cnt      <= '0;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
        end else if (!enable || seed_entry) begin
            entropy_data  <= '0;
            entropy_valid <= 1'b0;
            seed_cnt      <= '0;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
        end else begin
            case (state)
                SEED: seed_cnt <= seed_cnt + 1'b1;
                RUN: begin
                    sample_cnt <= tick ? '0 : sample_cnt + 1'b1;
                    if (tick) begin
                        entropy_data <= {entropy_data[WORD_WIDTH-2:0], ^raw_bits};
                        bit_cnt      <= bit_cnt + 1'b1;
                        if (last_bit) entropy_valid <= 1'b1;
                    end
                end
                HOLD: if (entropy_ack) begin
                    entropy_valid <= 1'b0;
                    bit_cnt       <= '0;
                    sample_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stuck_hit = 1'b0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            if (raw_bits[i] != prev_bits[i])            stuck_cnt_nxt[i] = '0;
            else if (stuck_cnt[i] == KCW'(STUCK_LIMIT)) stuck_cnt_nxt[i] = stuck_cnt[i];
            else                                        stuck_cnt_nxt[i] = stuck_cnt[i] + 1'b1;
            if (stuck_cnt_nxt[i] == KCW'(STUCK_LIMIT)) stuck_hit = 1'b1;
        end
    end

    // NOTE: the per-loop counter array is small and feeds a sticky flag, so it is reset explicitly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LOOPS; i++) stuck_cnt[i] <= '0;
            prev_bits   <= '0;
            have_prev   <= 1'b0;
            stuck_error <= 1'b0;
        end else if (seed_entry) begin
            for (int i = 0; i < NUM_LOOPS; i++) stuck_cnt[i] <= '0;
            have_prev   <= 1'b0;
            stuck_error <= 1'b0;
        end else if (state == RUN) begin
            if (tick) begin
                prev_bits <= raw_bits;
                have_prev <= 1'b1;
                if (have_prev) begin
                    for (int i = 0; i < NUM_LOOPS; i++) stuck_cnt[i] <= stuck_cnt_nxt[i];
                    if (stuck_hit) stuck_error <= 1'b1;
                end
            end
        end else begin
            // The first tick of every RUN stretch only records a reference value.
            have_prev <= 1'b0;
        end
    end
endmodule
